// File: rtl/rvfi_causal_multi_check.sv
// Register-dependency causality checker for an NRET-wide RVFI retirement bus.
// Optional memory-dependency tracking is enabled by defining RVFI_CAUSAL_MEM_EN.
module rvfi_causal_multi_check #(
    parameter int NRET     = 1,
    parameter int ORDER_W  = 64,
    parameter int CHECK_CH = 0,
`ifdef RVFI_CAUSAL_MEM_EN
    parameter int XLEN     = 32,
`endif
    parameter int CNT_W    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    check,
    input  logic [ORDER_W-1:0]      target_order,
    input  logic [4:0]              target_reg,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*ORDER_W-1:0] rvfi_order,
    input  logic [NRET*5-1:0]       rvfi_rs1_addr,
    input  logic [NRET*5-1:0]       rvfi_rs2_addr,
    input  logic [NRET*5-1:0]       rvfi_rd_addr,
`ifdef RVFI_CAUSAL_MEM_EN
    input  logic [NRET*XLEN-1:0]    rvfi_mem_addr,
    input  logic [NRET*XLEN/8-1:0]  rvfi_mem_rmask,
    input  logic [NRET*XLEN/8-1:0]  rvfi_mem_wmask,
    input  logic [XLEN-1:0]         target_addr,
`endif
    output logic [1:0]              state,
    output logic [CNT_W-1:0]        early_cnt,
    output logic                    fail,
    output logic                    dup_err
);

    localparam int SUM_W = CNT_W + $clog2(NRET + 1) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);
`ifdef RVFI_CAUSAL_MEM_EN
    localparam int WSH = $clog2(XLEN / 8);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WATCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  early_cnt_q, early_cnt_d;
    logic              fail_q, fail_d;
    logic              dup_err_q, dup_err_d;

    logic [NRET-1:0]   hit;
    logic [NRET-1:0]   ord_eq;
    logic              tgt;
    logic [SUM_W-1:0]  add_all, add_low;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [SUM_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + inc;
        return (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    endfunction

    // A hit is a younger instruction that read the target's destination before the target retired.
    always_comb begin
        hit     = '0;
        ord_eq  = '0;
        add_all = '0;
        add_low = '0;
        for (int c = 0; c < NRET; c++) begin
            ord_eq[c] = rvfi_valid[c] &&
                        (rvfi_order[c*ORDER_W +: ORDER_W] == target_order);
            hit[c] = rvfi_valid[c] &&
                     (rvfi_order[c*ORDER_W +: ORDER_W] > target_order) &&
                     (target_reg != 5'd0) &&
                     ((rvfi_rs1_addr[c*5 +: 5] == target_reg) ||
                      (rvfi_rs2_addr[c*5 +: 5] == target_reg));
`ifdef RVFI_CAUSAL_MEM_EN
            hit[c] = hit[c] ||
                     (rvfi_valid[c] &&
                      (rvfi_order[c*ORDER_W +: ORDER_W] > target_order) &&
                      (target_addr != '0) &&
                      (rvfi_mem_rmask[c*(XLEN/8) +: XLEN/8] != '0) &&
                      ((rvfi_mem_addr[c*XLEN +: XLEN] >> WSH) == (target_addr >> WSH)));
`endif
            add_all = add_all + SUM_W'(hit[c]);
            if (c < CHECK_CH) begin
                add_low = add_low + SUM_W'(hit[c]);
            end
        end
    end

    always_comb begin
        tgt = check && ord_eq[CHECK_CH] &&
              (rvfi_rd_addr[CHECK_CH*5 +: 5] == target_reg);
`ifdef RVFI_CAUSAL_MEM_EN
        tgt = tgt &&
              (rvfi_mem_wmask[CHECK_CH*(XLEN/8) +: XLEN/8] != '0) &&
              ((rvfi_mem_addr[CHECK_CH*XLEN +: XLEN] >> WSH) == (target_addr >> WSH));
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            early_cnt_q <= '0;
            fail_q      <= 1'b0;
            dup_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            early_cnt_q <= early_cnt_d;
            fail_q      <= fail_d;
            dup_err_q   <= dup_err_d;
        end
    end

    // On the target cycle only lower slots retired ahead of it; higher slots are causal.
    always_comb begin
        state_d     = state_q;
        early_cnt_d = early_cnt_q;
        fail_d      = fail_q;
        dup_err_d   = dup_err_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = WATCH;
                end
            end
            WATCH: begin
                if (tgt) begin
                    early_cnt_d = sat_add(early_cnt_q, add_low);
                    fail_d      = (sat_add(early_cnt_q, add_low) != '0);
                    state_d     = DONE;
                end else begin
                    early_cnt_d = sat_add(early_cnt_q, add_all);
                end
            end
            DONE: begin
                if (|ord_eq) begin
                    dup_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state     = state_q;
        early_cnt = early_cnt_q;
        fail      = fail_q;
        dup_err   = dup_err_q;
    end

endmodule

// File: tb/tb_rvfi_causal_multi_check.sv
// Bench for rvfi_causal_multi_check: two 2-channel instances share one bus,
// one checking channel 1 with a 2-bit counter, the other channel 0 with a 4-bit counter.
module tb_rvfi_causal_multi_check;

    logic         clock = 1'b0;
    logic         reset;
    logic         arm;
    logic         check;
    logic [63:0]  target_order;
    logic [4:0]   target_reg;
    logic [1:0]   rvfi_valid;
    logic [127:0] rvfi_order;
    logic [9:0]   rvfi_rs1_addr;
    logic [9:0]   rvfi_rs2_addr;
    logic [9:0]   rvfi_rd_addr;

    logic [1:0]   state_a, state_b;
    logic [1:0]   cnt_a;
    logic [3:0]   cnt_b;
    logic         fail_a, fail_b, dup_a, dup_b;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    rvfi_causal_multi_check #(.NRET(2), .ORDER_W(64), .CHECK_CH(1), .CNT_W(2)) dut_a (
        .clock(clock), .reset(reset), .arm(arm), .check(check),
        .target_order(target_order), .target_reg(target_reg),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rd_addr(rvfi_rd_addr),
        .state(state_a), .early_cnt(cnt_a), .fail(fail_a), .dup_err(dup_a)
    );

    rvfi_causal_multi_check #(.NRET(2), .ORDER_W(64), .CHECK_CH(0), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .arm(arm), .check(check),
        .target_order(target_order), .target_reg(target_reg),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rd_addr(rvfi_rd_addr),
        .state(state_b), .early_cnt(cnt_b), .fail(fail_b), .dup_err(dup_b)
    );

    typedef struct {
        logic        rst, arm, chk;
        logic [4:0]  treg;
        logic [1:0]  v;
        logic [63:0] o0, o1;
        logic [4:0]  a0, b0, d0, a1, b1, d1;
        logic [5:0]  exp_a;
        logic [7:0]  exp_b;
    } vec_t;

    localparam int NVEC = 19;
    localparam logic [63:0] HI_ORDER = 64'h8000_0000_0000_0000;
    vec_t vecs[NVEC];

    // exp_a = {state, cnt[1:0], fail, dup}; exp_b = {state, cnt[3:0], fail, dup}
    function automatic vec_t mk(input logic rst_i, input logic arm_i, input logic chk_i,
                                input logic [4:0] treg_i, input logic [1:0] v_i,
                                input logic [63:0] o0_i, input logic [4:0] a0_i,
                                input logic [4:0] b0_i, input logic [4:0] d0_i,
                                input logic [63:0] o1_i, input logic [4:0] a1_i,
                                input logic [4:0] b1_i, input logic [4:0] d1_i,
                                input logic [1:0] sa, input logic [1:0] ca,
                                input logic fa, input logic da,
                                input logic [1:0] sb, input logic [3:0] cb,
                                input logic fb, input logic db);
        vec_t r;
        r.rst = rst_i; r.arm = arm_i; r.chk = chk_i; r.treg = treg_i; r.v = v_i;
        r.o0 = o0_i; r.a0 = a0_i; r.b0 = b0_i; r.d0 = d0_i;
        r.o1 = o1_i; r.a1 = a1_i; r.b1 = b1_i; r.d1 = d1_i;
        r.exp_a = {sa, ca, fa, da};
        r.exp_b = {sb, cb, fb, db};
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset         = v.rst;
        arm           = v.arm;
        check         = v.chk;
        target_order  = 64'd10;
        target_reg    = v.treg;
        rvfi_valid    = v.v;
        rvfi_order    = {v.o1, v.o0};
        rvfi_rs1_addr = {v.a1, v.a0};
        rvfi_rs2_addr = {v.b1, v.b0};
        rvfi_rd_addr  = {v.d1, v.d0};
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] exp_a,
                               input logic [7:0] exp_b);
        logic [5:0] act_a;
        logic [7:0] act_b;
        act_a = {state_a, cnt_a, fail_a, dup_a};
        act_b = {state_b, cnt_b, fail_b, dup_b};
        total++;
        if (act_a !== exp_a) begin
            bad++;
            $display("[TB] FAIL %s dut_a {state,cnt,fail,dup} got=%b want=%b", name, act_a, exp_a);
        end
        total++;
        if (act_b !== exp_b) begin
            bad++;
            $display("[TB] FAIL %s dut_b {state,cnt,fail,dup} got=%b want=%b", name, act_b, exp_b);
        end
    endtask

    initial begin
        vec_t hv;

        reset = 1'b1; arm = 1'b0; check = 1'b0; target_order = 64'd10; target_reg = 5'd5;
        rvfi_valid = '0; rvfi_order = '0; rvfi_rs1_addr = '0; rvfi_rs2_addr = '0; rvfi_rd_addr = '0;

        // reset, then a younger reader before the target
        vecs[0]  = mk(1,0,0,5,2'b00, 0,0,0,0,   0,0,0,0, 0,0,0,0, 0,0,0,0);
        vecs[1]  = mk(0,1,0,5,2'b00, 0,0,0,0,   0,0,0,0, 1,0,0,0, 1,0,0,0);
        vecs[2]  = mk(0,0,0,5,2'b01, 12,5,0,0,  0,0,0,0, 1,1,0,0, 1,1,0,0);
        vecs[3]  = mk(0,0,1,5,2'b11, 10,0,0,5,  10,0,0,5, 2,1,1,0, 2,1,1,0);
        vecs[4]  = mk(0,1,0,5,2'b01, 10,0,0,0,  0,0,0,0, 2,1,1,1, 2,1,1,1);
        // older reader and unrelated younger reader are both causal
        vecs[5]  = mk(1,0,0,5,2'b00, 0,0,0,0,   0,0,0,0, 0,0,0,0, 0,0,0,0);
        vecs[6]  = mk(0,1,0,5,2'b00, 0,0,0,0,   0,0,0,0, 1,0,0,0, 1,0,0,0);
        vecs[7]  = mk(0,0,0,5,2'b01, 9,0,5,0,   0,0,0,0, 1,0,0,0, 1,0,0,0);
        vecs[8]  = mk(0,0,0,5,2'b01, 12,6,0,0,  0,0,0,0, 1,0,0,0, 1,0,0,0);
        vecs[9]  = mk(0,0,1,5,2'b11, 10,0,0,5,  10,0,0,5, 2,0,0,0, 2,0,0,0);
        // arm-cycle hit ignored; same-cycle lower slot counts only below CHECK_CH
        vecs[10] = mk(1,0,0,5,2'b00, 0,0,0,0,   0,0,0,0, 0,0,0,0, 0,0,0,0);
        vecs[11] = mk(0,1,0,5,2'b01, 12,5,0,0,  0,0,0,0, 1,0,0,0, 1,0,0,0);
        vecs[12] = mk(0,0,1,5,2'b11, 11,5,0,0,  10,0,0,5, 2,1,1,0, 1,1,0,0);
        vecs[13] = mk(1,0,0,5,2'b00, 0,0,0,0,   0,0,0,0, 0,0,0,0, 0,0,0,0);
        vecs[14] = mk(0,1,0,5,2'b00, 0,0,0,0,   0,0,0,0, 1,0,0,0, 1,0,0,0);
        vecs[15] = mk(0,0,1,5,2'b11, 10,0,0,5,  11,5,0,0, 1,1,0,0, 2,0,0,0);
        vecs[16] = mk(0,0,1,5,2'b01, HI_ORDER,0,5,5, 0,0,0,0, 1,2,0,0, 2,0,0,0);
        vecs[17] = mk(0,0,1,5,2'b10, 0,0,0,0,   10,5,0,5, 2,2,1,0, 2,0,0,1);
        vecs[18] = mk(1,0,0,5,2'b00, 0,0,0,0,   0,0,0,0, 0,0,0,0, 0,0,0,0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b);
        end

        // target_reg==0: x0 readers never count
        hv = mk(0,1,0,0,2'b00, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0);
        applyStimulus(hv);
        for (int i = 0; i < 10; i++) begin
            hv = mk(0,0,0,0,2'b11, 64'(11 + 2*i),0,0,0, 64'(12 + 2*i),0,0,0, 0,0,0,0, 0,0,0,0);
            applyStimulus(hv);
        end
        checkOutput("x0_readers", {2'd1, 2'd0, 1'b0, 1'b0}, {2'd1, 4'd0, 1'b0, 1'b0});
        hv = mk(0,0,1,0,2'b11, 10,0,0,0, 10,0,0,0, 0,0,0,0, 0,0,0,0);
        applyStimulus(hv);
        checkOutput("x0_target", {2'd2, 2'd0, 1'b0, 1'b0}, {2'd2, 4'd0, 1'b0, 1'b0});

        // saturation on the 2-bit counter, then reset mid-WATCH
        applyStimulus(mk(1,0,0,5,2'b00, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        applyStimulus(mk(0,1,0,5,2'b00, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        applyStimulus(mk(0,0,0,5,2'b11, 11,5,0,0, 12,0,5,0, 0,0,0,0, 0,0,0,0));
        checkOutput("sat_1", {2'd1, 2'd2, 1'b0, 1'b0}, {2'd1, 4'd2, 1'b0, 1'b0});
        applyStimulus(mk(0,0,0,5,2'b11, 13,5,0,0, 14,0,5,0, 0,0,0,0, 0,0,0,0));
        checkOutput("sat_2", {2'd1, 2'd3, 1'b0, 1'b0}, {2'd1, 4'd4, 1'b0, 1'b0});
        applyStimulus(mk(0,0,0,5,2'b01, 15,5,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        checkOutput("sat_3", {2'd1, 2'd3, 1'b0, 1'b0}, {2'd1, 4'd5, 1'b0, 1'b0});
        applyStimulus(mk(1,0,0,5,2'b00, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        checkOutput("mid_reset", {2'd0, 2'd0, 1'b0, 1'b0}, {2'd0, 4'd0, 1'b0, 1'b0});

        // re-arm, saturate again and retire the target
        applyStimulus(mk(0,1,0,5,2'b00, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
        applyStimulus(mk(0,0,0,5,2'b11, 11,5,0,0, 12,5,0,0, 0,0,0,0, 0,0,0,0));
        applyStimulus(mk(0,0,0,5,2'b11, 13,0,5,0, 14,0,5,0, 0,0,0,0, 0,0,0,0));
        checkOutput("resat", {2'd1, 2'd3, 1'b0, 1'b0}, {2'd1, 4'd4, 1'b0, 1'b0});
        applyStimulus(mk(0,0,1,5,2'b11, 10,0,0,5, 10,0,0,5, 0,0,0,0, 0,0,0,0));
        checkOutput("sat_target", {2'd2, 2'd3, 1'b1, 1'b0}, {2'd2, 4'd4, 1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
